// File: rtl/submatrix_downsampler_if.sv
// submatrix_downsampler_if
//   This interface groups the handshake and bus signals of the submatrix downsampler.
//   Upstream side:
//     loaded            - strobe; submatrixElements is valid in this cycle
//     submatrixElements - 4x4 binary group; bit 15 is the first pixel read
//     readyToBeLoaded   - the downsampler can accept a submatrix
//   Output image RAM side:
//     wrEn              - write strobe, one cycle per submatrix
//     wrAddr            - RAM address
//     wrData            - downsampled pixel
//   Modports:
//     master - the stage that feeds submatrices and observes the RAM port
//     slave  - the downsampler itself
interface submatrix_downsampler_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  loaded;
    logic [15:0]           submatrixElements;
    logic                  readyToBeLoaded;
    logic                  wrEn;
    logic [ADDR_WIDTH-1:0] wrAddr;
    logic                  wrData;

    modport master (
        output loaded,
        output submatrixElements,
        input  readyToBeLoaded,
        input  wrEn,
        input  wrAddr,
        input  wrData
    );

    modport slave (
        input  loaded,
        input  submatrixElements,
        output readyToBeLoaded,
        output wrEn,
        output wrAddr,
        output wrData
    );
endinterface

// File: rtl/submatrix_downsampler.sv
// submatrix_downsampler
//   This module reduces each 16-bit 4x4 binary submatrix to one output pixel.
//   A pixel is 1 when the popcount of its submatrix is at least THRESHOLD. The popcount is
//   built one nibble per cycle, starting with [15:12]. Each pixel is written to a
//   1-bit-wide output image RAM. One frame is NUM_GROUPS submatrices.
//   Ports:
//     clock   - system clock; all logic runs on the rising edge
//     resetN  - synchronous, active-low reset
//     start   - pulse that begins a new frame; it is honoured only in IDLE or DONE
//     bus     - slave modport of submatrix_downsampler_if (upstream handshake + RAM write port)
//     done    - high while the frame is complete
//     overrun - sticky flag; loaded was seen while the block was not ready
//     onesCount - number of 1 pixels written this frame, saturating
//                 (present only when SUBMATRIX_DOWNSAMPLE_STATS_EN is defined)
//   Build option: define SUBMATRIX_DOWNSAMPLE_STATS_EN to add the onesCount port and its counter.
module submatrix_downsampler #(
    parameter int NUM_GROUPS = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int THRESHOLD  = 8
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  start,
    submatrix_downsampler_if.slave bus,
    output logic                  done,
    output logic                  overrun
`ifdef SUBMATRIX_DOWNSAMPLE_STATS_EN
    ,
    output logic [ADDR_WIDTH:0]   onesCount
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOAD,
        COUNT,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_GROUPS - 1);
    localparam logic [5:0]            THRESH    = 6'(THRESHOLD);

    state_t                state;
    logic [15:0]           shifter;
    logic [4:0]            acc;
    logic [1:0]            nibble_idx;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ready;
    logic                  wr_en;
    logic                  wr_data;
    logic [4:0]            acc_next;
    logic                  pixel_next;
`ifdef SUBMATRIX_DOWNSAMPLE_STATS_EN
    logic [ADDR_WIDTH:0]   ones;
`endif

    function automatic logic [2:0] nibble_ones(input logic [3:0] n);
        return {2'b00, n[3]} + {2'b00, n[2]} + {2'b00, n[1]} + {2'b00, n[0]};
    endfunction

    // The running count with the current top nibble added. The latched submatrix is shifted
    // left each COUNT cycle, so [15:12] is always the next nibble. The compare is one bit
    // wider than the count, which lets THRESHOLD=16 work and makes THRESHOLD=0 always true.
    always_comb begin
        acc_next   = acc + {2'b00, nibble_ones(shifter[15:12])};
        pixel_next = ({1'b0, acc_next} >= THRESH);
    end

    // This block holds the frame FSM and all of the registered outputs.
    // It accepts a submatrix in WAIT_LOAD. It counts for 4 cycles, then spends 1 cycle in
    // WRITE with wrEn high. A loaded strobe in any other state is dropped and raises overrun.
    // In IDLE and DONE, start has priority over loaded.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state      <= IDLE;
            shifter    <= '0;
            acc        <= '0;
            nibble_idx <= '0;
            addr       <= '0;
            ready      <= 1'b0;
            wr_en      <= 1'b0;
            wr_data    <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
`ifdef SUBMATRIX_DOWNSAMPLE_STATS_EN
            ones       <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= WAIT_LOAD;
                        ready   <= 1'b1;
                        done    <= 1'b0;
                        addr    <= '0;
                        overrun <= 1'b0;
`ifdef SUBMATRIX_DOWNSAMPLE_STATS_EN
                        ones    <= '0;
`endif
                    end else if (bus.loaded) begin
                        overrun <= 1'b1;
                    end
                end
                WAIT_LOAD: begin
                    if (bus.loaded) begin
                        shifter    <= bus.submatrixElements;
                        acc        <= '0;
                        nibble_idx <= '0;
                        ready      <= 1'b0;
                        state      <= COUNT;
                    end
                end
                COUNT: begin
                    if (bus.loaded) begin
                        overrun <= 1'b1;
                    end
                    acc        <= acc_next;
                    shifter    <= {shifter[11:0], 4'b0000};
                    nibble_idx <= nibble_idx + 2'd1;
                    if (nibble_idx == 2'd3) begin
                        wr_data <= pixel_next;
                        wr_en   <= 1'b1;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus.loaded) begin
                        overrun <= 1'b1;
                    end
                    wr_en <= 1'b0;
`ifdef SUBMATRIX_DOWNSAMPLE_STATS_EN
                    if (wr_data && (ones != '1)) begin
                        ones <= ones + 1'b1;
                    end
`endif
                    if (addr < LAST_ADDR) begin
                        addr  <= addr + 1'b1;
                        ready <= 1'b1;
                        state <= WAIT_LOAD;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.readyToBeLoaded = ready;
    assign bus.wrEn            = wr_en;
    assign bus.wrAddr          = addr;
    assign bus.wrData          = wr_data;
`ifdef SUBMATRIX_DOWNSAMPLE_STATS_EN
    assign onesCount           = ones;
`endif

endmodule

// File: tb/tb_submatrix_downsampler.sv
// tb_submatrix_downsampler
//   This bench drives three downsamplers from the same stimulus. Each has NUM_GROUPS=4, and
//   their thresholds are 8, 0 and 16. Expected pixels come from $countones of each accepted
//   submatrix, compared against that instance's threshold. Expected addresses, done and
//   overrun come from a frame-level model of the handshake.
module tb_submatrix_downsampler;

    localparam int NG = 4;
    localparam int AW = 2;

    logic        clock;
    logic        resetN;
    logic        start;
    logic        loaded;
    logic [15:0] elements;

    logic done8, done0, done16;
    logic ovr8, ovr0, ovr16;
`ifdef SUBMATRIX_DOWNSAMPLE_STATS_EN
    logic [AW:0] ones8, ones0, ones16;
`endif

    int assertions = 0;
    int failures   = 0;
    int expAddr    = 0;
    int expOnes    = 0;
    logic expOverrun = 1'b0;

    submatrix_downsampler_if #(.ADDR_WIDTH(AW)) bus8 ();
    submatrix_downsampler_if #(.ADDR_WIDTH(AW)) bus0 ();
    submatrix_downsampler_if #(.ADDR_WIDTH(AW)) bus16 ();

    assign bus8.loaded             = loaded;
    assign bus8.submatrixElements  = elements;
    assign bus0.loaded             = loaded;
    assign bus0.submatrixElements  = elements;
    assign bus16.loaded            = loaded;
    assign bus16.submatrixElements = elements;

    submatrix_downsampler #(.NUM_GROUPS(NG), .ADDR_WIDTH(AW), .THRESHOLD(8)) dut8 (
        .clock(clock), .resetN(resetN), .start(start), .bus(bus8.slave),
        .done(done8), .overrun(ovr8)
`ifdef SUBMATRIX_DOWNSAMPLE_STATS_EN
        , .onesCount(ones8)
`endif
    );

    submatrix_downsampler #(.NUM_GROUPS(NG), .ADDR_WIDTH(AW), .THRESHOLD(0)) dut0 (
        .clock(clock), .resetN(resetN), .start(start), .bus(bus0.slave),
        .done(done0), .overrun(ovr0)
`ifdef SUBMATRIX_DOWNSAMPLE_STATS_EN
        , .onesCount(ones0)
`endif
    );

    submatrix_downsampler #(.NUM_GROUPS(NG), .ADDR_WIDTH(AW), .THRESHOLD(16)) dut16 (
        .clock(clock), .resetN(resetN), .start(start), .bus(bus16.slave),
        .done(done16), .overrun(ovr16)
`ifdef SUBMATRIX_DOWNSAMPLE_STATS_EN
        , .onesCount(ones16)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // This task checks all three instances in the cycle where they should present a write.
    task automatic checkOutput(input logic [15:0] v);
        int pop;
        pop = $countones(v);
        check("wrEn8", 32'(bus8.wrEn), 32'd1);
        check("wrEn0", 32'(bus0.wrEn), 32'd1);
        check("wrEn16", 32'(bus16.wrEn), 32'd1);
        check("wrAddr8", 32'(bus8.wrAddr), 32'(expAddr));
        check("wrAddr16", 32'(bus16.wrAddr), 32'(expAddr));
        check("wrData8", 32'(bus8.wrData), 32'(pop >= 8));
        check("wrData0", 32'(bus0.wrData), 32'(pop >= 0));
        check("wrData16", 32'(bus16.wrData), 32'(pop >= 16));
        if (pop >= 8) expOnes++;
    endtask

    // Begins at a falling edge. After this task, the start edge has passed.
    task automatic pulseStart();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        expAddr    = 0;
        expOnes    = 0;
        expOverrun = 1'b0;
        check("start_ready", 32'(bus8.readyToBeLoaded), 32'd1);
        check("start_done", 32'({done8, done0, done16}), 32'd0);
        check("start_addr", 32'(bus8.wrAddr), 32'd0);
        check("start_overrun", 32'({ovr8, ovr0, ovr16}), 32'd0);
    endtask

    // This task sends one submatrix once the block is ready, then follows it through the
    // edges E1..E5. When glitch is set, it also pulses loaded during COUNT.
    task automatic applyStimulus(input logic [15:0] v, input bit last, input bit glitch);
        for (int w = 0; w < 10 && !bus8.readyToBeLoaded; w++) @(negedge clock);
        check("ready_wait", 32'(bus8.readyToBeLoaded), 32'd1);
        loaded   = 1'b1;
        elements = v;
        @(negedge clock);
        loaded = 1'b0;
        check("ready_after_accept", 32'(bus8.readyToBeLoaded), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            loaded = glitch && (i == 2);
            if (glitch && (i == 2)) begin
                elements   = ~v;
                expOverrun = 1'b1;
            end
            @(negedge clock);
            loaded = 1'b0;
            if (i < 4) begin
                check("wrEn_early", 32'({bus8.wrEn, bus0.wrEn, bus16.wrEn}), 32'd0);
            end else if (i == 4) begin
                checkOutput(v);
            end else begin
                check("wrEn_after", 32'({bus8.wrEn, bus0.wrEn, bus16.wrEn}), 32'd0);
                check("done", 32'(done8), 32'(last));
                check("ready_after_write", 32'(bus8.readyToBeLoaded), 32'(!last));
                check("addr_after_write", 32'(bus8.wrAddr), 32'(last ? NG - 1 : expAddr + 1));
                check("overrun", 32'({ovr8, ovr16}), {30'd0, expOverrun, expOverrun});
                if (!last) expAddr++;
            end
        end
    endtask

    task automatic checkOnes();
`ifdef SUBMATRIX_DOWNSAMPLE_STATS_EN
        check("onesCount8", 32'(ones8), 32'(expOnes));
`endif
    endtask

    initial begin
        logic [15:0] frameA [4];
        logic [15:0] frameB [4];
        logic [15:0] held [25];
        logic [15:0] acceptedVal;

        frameA = '{16'hFFFF, 16'h0000, 16'h00FF, 16'h007F};
        frameB = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'($urandom)};
        acceptedVal = '0;

        // Reset is held while loaded is high.
        resetN   = 1'b0;
        start    = 1'b0;
        loaded   = 1'b1;
        elements = 16'($urandom);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_outputs", 32'({bus8.readyToBeLoaded, bus8.wrEn, bus8.wrData, done8, ovr8}), 32'd0);
        check("rst_addr", 32'(bus8.wrAddr), 32'd0);
        check("rst_others", 32'({bus0.wrEn, bus16.wrEn, done0, done16, ovr0, ovr16}), 32'd0);
        loaded = 1'b0;
        resetN = 1'b1;
        @(negedge clock);
        check("idle_quiet", 32'({bus8.readyToBeLoaded, done8, ovr8}), 32'd0);

        // First directed frame.
        pulseStart();
        for (int k = 0; k < 4; k++) applyStimulus(frameA[k], k == 3, 1'b0);
        checkOnes();

        // Continuous loaded: the frame restarts from DONE with loaded held high.
        // Accepts are expected at edges 1, 7, 13, 19 after start.
        start    = 1'b1;
        loaded   = 1'b1;
        elements = 16'($urandom);
        @(negedge clock);
        start = 1'b0;
        expAddr = 0;
        expOnes = 0;
        check("held_start_overrun", 32'(ovr8), 32'd0);
        check("held_start_ready", 32'(bus8.readyToBeLoaded), 32'd1);
        for (int c = 1; c <= 24; c++) begin
            held[c]  = 16'($urandom);
            elements = held[c];
            @(negedge clock);
            if (c % 6 == 1) acceptedVal = held[c];
            if (c % 6 == 5) begin
                expAddr = (c - 5) / 6;
                checkOutput(acceptedVal);
            end else begin
                check("held_wrEn", 32'(bus8.wrEn), 32'd0);
            end
            check("held_ready", 32'(bus8.readyToBeLoaded), 32'((c % 6 == 0) && (c < 24)));
        end
        loaded = 1'b0;
        check("held_done", 32'({done8, done0, done16}), 32'b111);
        check("held_overrun", 32'(ovr8), 32'd1);
        checkOnes();

        // A start in DONE clears overrun and the address. Loaded pulses during COUNT are dropped.
        pulseStart();
        for (int k = 0; k < 4; k++) applyStimulus(frameB[k], k == 3, k == 1);
        checkOnes();

        // Reset during COUNT aborts the frame. A later start restarts at address 0.
        pulseStart();
        applyStimulus(16'($urandom), 1'b0, 1'b0);
        for (int w = 0; w < 10 && !bus8.readyToBeLoaded; w++) @(negedge clock);
        loaded   = 1'b1;
        elements = 16'hFFFF;
        @(negedge clock);
        loaded = 1'b0;
        @(negedge clock);
        resetN = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("abort_wrEn", 32'({bus8.wrEn, bus0.wrEn, bus16.wrEn}), 32'd0);
            check("abort_state", 32'({bus8.readyToBeLoaded, done8, 1'b0, bus8.wrAddr}), 32'd0);
            @(negedge clock);
        end

        // Random frames.
        for (int f = 0; f < 3; f++) begin
            pulseStart();
            for (int k = 0; k < 4; k++) applyStimulus(16'($urandom), k == 3, 1'b0);
            checkOnes();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
